// File: rtl/gpu_pkg.sv
// Shared GPU core types: CDB field widths and the buffered write-back entry.
package gpu_pkg;

    localparam int unsigned CDB_DATA_W = 256;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned SCBID_W    = 2;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned WARP_W     = 3;

    typedef struct packed {
        logic [WARP_W-1:0]     warp;
        logic [REG_ADDR_W-1:0] dst;
        logic [SCBID_W-1:0]    scbid;
        logic [CDB_DATA_W-1:0] data;
        logic [INSTR_W-1:0]    instr;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO for one CDB source; pushes into a full FIFO and pops
// from an empty one are dropped, so a full FIFO never accepts even while popping.
module cdb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = logic
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 wdata,
    output entry_t                 rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
            if (pop_ok)  rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/cdb_writeback.sv
// CDB write-back: buffers ALU and MEM results, round-robin arbitrates them and
// drives one registered RFOC write plus scoreboard clear per cycle.
module cdb_writeback
    import gpu_pkg::*;
#(
    parameter int unsigned NUM_WARPS    = 8,
    parameter int unsigned LOGNUM_WARPS = $clog2(NUM_WARPS),
    parameter int unsigned DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Valid_ALU_CDB,
    output logic                    Ready_CDB_ALU,
    input  logic [LOGNUM_WARPS-1:0] WarpID_ALU_CDB,
    input  logic [REG_ADDR_W-1:0]   Dst_ALU_CDB,
    input  logic [SCBID_W-1:0]      ScbID_ALU_CDB,
    input  logic [CDB_DATA_W-1:0]   Data_ALU_CDB,
    input  logic [INSTR_W-1:0]      Instr_ALU_CDB,
    input  logic                    Valid_MEM_CDB,
    output logic                    Ready_CDB_MEM,
    input  logic [LOGNUM_WARPS-1:0] WarpID_MEM_CDB,
    input  logic [REG_ADDR_W-1:0]   Dst_MEM_CDB,
    input  logic [SCBID_W-1:0]      ScbID_MEM_CDB,
    input  logic [CDB_DATA_W-1:0]   Data_MEM_CDB,
    input  logic [INSTR_W-1:0]      Instr_MEM_CDB,
    output logic                    RegWrite_CDB_OC,
    output logic [REG_ADDR_W-1:0]   WriteAddr_CDB_OC,
    output logic [WARP_W-1:0]       HWWarp_CDB_OC,
    output logic [CDB_DATA_W-1:0]   Data_CDB_OC,
    output logic [INSTR_W-1:0]      Instr_CDB_OC,
    output logic                    Clear_Valid_CDB_Scb,
    output logic [SCBID_W-1:0]      Clear_ScbID_CDB_Scb,
    output logic [LOGNUM_WARPS-1:0] Clear_WarpID_CDB_Scb,
    output logic                    Idle_CDB
);

    cdb_entry_t             alu_in, mem_in, alu_head, mem_head, out_q;
    logic [$clog2(DEPTH):0] alu_count, mem_count;
    logic                   alu_empty, mem_empty, alu_full, mem_full;
    logic                   pop_alu, pop_mem;
    logic                   we_q;
    logic                   last_q;  // 0: ALU served last, 1: MEM served last

    assign alu_in = '{warp: WARP_W'(WarpID_ALU_CDB), dst: Dst_ALU_CDB, scbid: ScbID_ALU_CDB,
                      data: Data_ALU_CDB, instr: Instr_ALU_CDB};
    assign mem_in = '{warp: WARP_W'(WarpID_MEM_CDB), dst: Dst_MEM_CDB, scbid: ScbID_MEM_CDB,
                      data: Data_MEM_CDB, instr: Instr_MEM_CDB};

    assign Ready_CDB_ALU = !alu_full;
    assign Ready_CDB_MEM = !mem_full;

    cdb_fifo #(.DEPTH(DEPTH), .entry_t(cdb_entry_t)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (Valid_ALU_CDB && Ready_CDB_ALU),
        .pop   (pop_alu),
        .wdata (alu_in),
        .rdata (alu_head),
        .count (alu_count),
        .empty (alu_empty),
        .full  (alu_full)
    );

    cdb_fifo #(.DEPTH(DEPTH), .entry_t(cdb_entry_t)) u_mem_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (Valid_MEM_CDB && Ready_CDB_MEM),
        .pop   (pop_mem),
        .wdata (mem_in),
        .rdata (mem_head),
        .count (mem_count),
        .empty (mem_empty),
        .full  (mem_full)
    );

    always_comb begin
        pop_alu = 1'b0;
        pop_mem = 1'b0;
        if (!alu_empty && !mem_empty) begin
            pop_alu = last_q;
            pop_mem = !last_q;
        end else if (!alu_empty) begin
            pop_alu = 1'b1;
        end else if (!mem_empty) begin
            pop_mem = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            out_q  <= '0;
            last_q <= 1'b1;
        end else begin
            we_q <= pop_alu || pop_mem;
            if (pop_alu || pop_mem) begin
                out_q  <= pop_alu ? alu_head : mem_head;
                last_q <= pop_mem;
            end
        end
    end

    assign RegWrite_CDB_OC      = we_q;
    assign Clear_Valid_CDB_Scb  = we_q;
    assign WriteAddr_CDB_OC     = out_q.dst;
    assign HWWarp_CDB_OC        = out_q.warp;
    assign Data_CDB_OC          = out_q.data;
    assign Instr_CDB_OC         = out_q.instr;
    assign Clear_ScbID_CDB_Scb  = out_q.scbid;
    assign Clear_WarpID_CDB_Scb = LOGNUM_WARPS'(out_q.warp);
    assign Idle_CDB             = !we_q && (alu_count == '0) && (mem_count == '0);

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback: vector table for single/tie/mixed traffic,
// hand sequences for saturation, full FIFO, mid-operation reset and MEM streaming.
module tb_cdb_writeback;
    import gpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         Valid_ALU_CDB, Ready_CDB_ALU, Valid_MEM_CDB, Ready_CDB_MEM;
    logic [2:0]   WarpID_ALU_CDB, Dst_ALU_CDB, WarpID_MEM_CDB, Dst_MEM_CDB;
    logic [1:0]   ScbID_ALU_CDB, ScbID_MEM_CDB;
    logic [255:0] Data_ALU_CDB, Data_MEM_CDB;
    logic [31:0]  Instr_ALU_CDB, Instr_MEM_CDB;
    logic         RegWrite_CDB_OC, Clear_Valid_CDB_Scb, Idle_CDB;
    logic [2:0]   WriteAddr_CDB_OC, HWWarp_CDB_OC, Clear_WarpID_CDB_Scb;
    logic [255:0] Data_CDB_OC;
    logic [31:0]  Instr_CDB_OC;
    logic [1:0]   Clear_ScbID_CDB_Scb;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] log_q[$];

    cdb_writeback #(.NUM_WARPS(8), .LOGNUM_WARPS(3), .DEPTH(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .Valid_ALU_CDB        (Valid_ALU_CDB),
        .Ready_CDB_ALU        (Ready_CDB_ALU),
        .WarpID_ALU_CDB       (WarpID_ALU_CDB),
        .Dst_ALU_CDB          (Dst_ALU_CDB),
        .ScbID_ALU_CDB        (ScbID_ALU_CDB),
        .Data_ALU_CDB         (Data_ALU_CDB),
        .Instr_ALU_CDB        (Instr_ALU_CDB),
        .Valid_MEM_CDB        (Valid_MEM_CDB),
        .Ready_CDB_MEM        (Ready_CDB_MEM),
        .WarpID_MEM_CDB       (WarpID_MEM_CDB),
        .Dst_MEM_CDB          (Dst_MEM_CDB),
        .ScbID_MEM_CDB        (ScbID_MEM_CDB),
        .Data_MEM_CDB         (Data_MEM_CDB),
        .Instr_MEM_CDB        (Instr_MEM_CDB),
        .RegWrite_CDB_OC      (RegWrite_CDB_OC),
        .WriteAddr_CDB_OC     (WriteAddr_CDB_OC),
        .HWWarp_CDB_OC        (HWWarp_CDB_OC),
        .Data_CDB_OC          (Data_CDB_OC),
        .Instr_CDB_OC         (Instr_CDB_OC),
        .Clear_Valid_CDB_Scb  (Clear_Valid_CDB_Scb),
        .Clear_ScbID_CDB_Scb  (Clear_ScbID_CDB_Scb),
        .Clear_WarpID_CDB_Scb (Clear_WarpID_CDB_Scb),
        .Idle_CDB             (Idle_CDB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        va;
        logic [2:0]  aw, ad;
        logic [1:0]  as;
        logic [31:0] aword;
        logic        vm;
        logic [2:0]  mw, md;
        logic [1:0]  ms;
        logic [31:0] mword;
        logic        ewe;
        logic [2:0]  eaddr, ewarp;
        logic [1:0]  escb;
        logic [31:0] eword;
        logic        eidle;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction

    task automatic tick();
        @(negedge clk);
        if (RegWrite_CDB_OC) log_q.push_back(Data_CDB_OC[31:0]);
    endtask

    task automatic drive_alu(input logic v, input logic [2:0] w, input logic [2:0] d,
                             input logic [1:0] s, input logic [31:0] word);
        Valid_ALU_CDB  = v;
        WarpID_ALU_CDB = w;
        Dst_ALU_CDB    = d;
        ScbID_ALU_CDB  = s;
        Data_ALU_CDB   = {8{word}};
        Instr_ALU_CDB  = swap(word);
    endtask

    task automatic drive_mem(input logic v, input logic [2:0] w, input logic [2:0] d,
                             input logic [1:0] s, input logic [31:0] word);
        Valid_MEM_CDB  = v;
        WarpID_MEM_CDB = w;
        Dst_MEM_CDB    = d;
        ScbID_MEM_CDB  = s;
        Data_MEM_CDB   = {8{word}};
        Instr_MEM_CDB  = swap(word);
    endtask

    task automatic alu_item(input logic v, input int i);
        drive_alu(v, 3'(i), 3'(i + 1), 2'(i), 32'hA000_0000 + i);
    endtask

    task automatic mem_item(input logic v, input int i);
        drive_mem(v, 3'(7 - i), 3'(i), 2'(i), 32'hB000_0000 + i);
    endtask

    task automatic do_reset();
        drive_alu(1'b0, 3'd0, 3'd0, 2'd0, 32'd0);
        drive_mem(1'b0, 3'd0, 3'd0, 2'd0, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic check_out(input string tag, input logic we, input logic [2:0] addr,
                             input logic [2:0] warp, input logic [1:0] scb,
                             input logic [31:0] word, input logic idle);
        chk({tag, ".we"}, RegWrite_CDB_OC, we);
        chk({tag, ".clr_valid"}, Clear_Valid_CDB_Scb, we);
        chk({tag, ".addr"}, WriteAddr_CDB_OC, addr);
        chk({tag, ".warp"}, HWWarp_CDB_OC, warp);
        chk({tag, ".clr_warp"}, Clear_WarpID_CDB_Scb, warp);
        chk({tag, ".clr_scb"}, Clear_ScbID_CDB_Scb, scb);
        chk({tag, ".data"}, Data_CDB_OC, {8{word}});
        chk({tag, ".instr"}, Instr_CDB_OC, swap(word));
        chk({tag, ".idle"}, Idle_CDB, idle);
    endtask

    // Walks the commit log: per-source order, per-source totals, and strict
    // MEM/ALU alternation over the first alt_n commits.
    task automatic verify_log(input string tag, input int n_alu, input int n_mem,
                              input int alt_n);
        int ea = 0;
        int em = 0;
        chk({tag, ".commits"}, log_q.size(), n_alu + n_mem);
        for (int k = 0; k < log_q.size(); k++) begin
            if (log_q[k][31:28] == 4'hA) begin
                chk($sformatf("%s.alu_order%0d", tag, k), log_q[k], 32'hA000_0000 + ea);
                ea++;
            end else begin
                chk($sformatf("%s.mem_order%0d", tag, k), log_q[k], 32'hB000_0000 + em);
                em++;
            end
            if (k < alt_n)
                chk($sformatf("%s.alt%0d", tag, k), log_q[k][31:28], (k % 2 == 0) ? 4'hB : 4'hA);
        end
        chk({tag, ".alu_total"}, ea, n_alu);
        chk({tag, ".mem_total"}, em, n_mem);
    endtask

    initial begin
        logic a_acc, m_acc;
        int   ai, mi;

        // va aw ad as aword  vm mw md ms mword  we addr warp scb word  idle
        tbl[0]  = '{1, 1, 1, 1, 32'hC0DE_0001, 1, 2, 2, 3, 32'hC0DE_0002, 0, 0, 0, 0, 32'h0, 0};
        tbl[1]  = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 1, 1, 1, 32'hC0DE_0001, 0};
        tbl[2]  = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 2, 2, 3, 32'hC0DE_0002, 0};
        tbl[3]  = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 2, 2, 3, 32'hC0DE_0002, 1};
        tbl[4]  = '{0, 0, 0, 0, 32'h0, 1, 4, 6, 0, 32'hC0DE_0044, 0, 2, 2, 3, 32'hC0DE_0002, 0};
        tbl[5]  = '{0, 0, 0, 0, 32'h0, 1, 5, 7, 1, 32'hC0DE_0055, 1, 6, 4, 0, 32'hC0DE_0044, 0};
        tbl[6]  = '{1, 6, 3, 2, 32'hC0DE_0066, 0, 0, 0, 0, 32'h0, 1, 7, 5, 1, 32'hC0DE_0055, 0};
        tbl[7]  = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 3, 6, 2, 32'hC0DE_0066, 0};
        tbl[8]  = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 3, 6, 2, 32'hC0DE_0066, 1};
        tbl[9]  = '{1, 7, 4, 3, 32'hC0DE_0077, 1, 0, 0, 0, 32'hC0DE_0080, 0, 3, 6, 2, 32'hC0DE_0066, 0};
        tbl[10] = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'hC0DE_0080, 0};
        tbl[11] = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 4, 7, 3, 32'hC0DE_0077, 0};
        tbl[12] = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 4, 7, 3, 32'hC0DE_0077, 1};

        // Reset values
        do_reset();
        check_out("reset", 1'b0, 3'd0, 3'd0, 2'd0, 32'd0, 1'b1);
        chk("reset.rdy_alu", Ready_CDB_ALU, 1'b1);
        chk("reset.rdy_mem", Ready_CDB_MEM, 1'b1);

        // Single ALU result: one cycle to buffer, then one CDB cycle
        drive_alu(1'b1, 3'd3, 3'd5, 2'd2, 32'hA5A5_A5A5);
        tick();
        drive_alu(1'b0, 3'd0, 3'd0, 2'd0, 32'd0);
        chk("single.buffered_we", RegWrite_CDB_OC, 1'b0);
        chk("single.buffered_idle", Idle_CDB, 1'b0);
        tick();
        check_out("single.commit", 1'b1, 3'd5, 3'd3, 2'd2, 32'hA5A5_A5A5, 1'b0);
        tick();
        check_out("single.after", 1'b0, 3'd5, 3'd3, 2'd2, 32'hA5A5_A5A5, 1'b1);

        // Vector table, starting from reset so ALU wins the first tie
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive_alu(tbl[i].va, tbl[i].aw, tbl[i].ad, tbl[i].as, tbl[i].aword);
            drive_mem(tbl[i].vm, tbl[i].mw, tbl[i].md, tbl[i].ms, tbl[i].mword);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].ewe, tbl[i].eaddr, tbl[i].ewarp,
                      tbl[i].escb, tbl[i].eword, tbl[i].eidle);
            chk($sformatf("vec%0d.rdy_alu", i), Ready_CDB_ALU, 1'b1);
            chk($sformatf("vec%0d.rdy_mem", i), Ready_CDB_MEM, 1'b1);
        end

        // Both saturated; table leaves ALU as last served, so MEM commits first
        log_q.delete();
        ai = 0;
        mi = 0;
        for (int c = 0; c < 40; c++) begin
            alu_item(ai < 8, ai);
            mem_item(mi < 8, mi);
            a_acc = Valid_ALU_CDB && Ready_CDB_ALU;
            m_acc = Valid_MEM_CDB && Ready_CDB_MEM;
            tick();
            if (a_acc) ai++;
            if (m_acc) mi++;
        end
        alu_item(1'b0, 0);
        mem_item(1'b0, 0);
        verify_log("sat", 8, 8, 8);
        chk("sat.idle", Idle_CDB, 1'b1);

        // ALU FIFO full: the held ALU item must enter exactly once
        do_reset();
        log_q.delete();
        alu_item(1'b1, 0);
        mem_item(1'b0, 0);
        tick();
        alu_item(1'b1, 1);
        mem_item(1'b1, 0);
        tick();
        alu_item(1'b1, 2);
        mem_item(1'b1, 1);
        tick();
        chk("full.rdy_alu_low", Ready_CDB_ALU, 1'b0);
        chk("full.rdy_mem", Ready_CDB_MEM, 1'b1);
        alu_item(1'b1, 3);
        mem_item(1'b1, 2);
        tick();
        chk("full.rdy_alu_back", Ready_CDB_ALU, 1'b1);
        alu_item(1'b1, 3);
        mem_item(1'b0, 0);
        tick();
        alu_item(1'b0, 0);
        repeat (6) tick();
        verify_log("full", 4, 3, 0);

        // Reset while both FIFOs hold entries and a commit is on the bus
        log_q.delete();
        alu_item(1'b1, 0);
        mem_item(1'b1, 0);
        tick();
        alu_item(1'b1, 1);
        mem_item(1'b1, 1);
        tick();
        alu_item(1'b0, 0);
        mem_item(1'b0, 0);
        tick();
        chk("midrst.pre_we", RegWrite_CDB_OC, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midrst.we", RegWrite_CDB_OC, 1'b0);
        chk("midrst.clr_valid", Clear_Valid_CDB_Scb, 1'b0);
        chk("midrst.rdy_alu", Ready_CDB_ALU, 1'b1);
        chk("midrst.rdy_mem", Ready_CDB_MEM, 1'b1);
        chk("midrst.idle", Idle_CDB, 1'b1);
        chk("midrst.data", Data_CDB_OC, 256'd0);
        tick();
        tick();
        #2 rst = 1'b1;
        log_q.delete();
        repeat (4) tick();
        chk("midrst.stale_commits", log_q.size(), 0);
        chk("midrst.idle_after", Idle_CDB, 1'b1);

        // MEM-only stream: four back-to-back CDB cycles, Ready never drops
        do_reset();
        for (int k = 0; k < 6; k++) begin
            mem_item(k < 4, k);
            tick();
            chk($sformatf("b2b%0d.rdy_mem", k), Ready_CDB_MEM, 1'b1);
            chk($sformatf("b2b%0d.we", k), RegWrite_CDB_OC, (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4)
                chk($sformatf("b2b%0d.data", k), Data_CDB_OC[31:0], 32'hB000_0000 + k - 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
